// File: rtl/demux3_pkg.sv
// Shared constants for the 1-to-3 stream demultiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package demux3_pkg;

    localparam int NUM_LANES = 3;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;

    // Destination select encoding; the spare code marks a word to be dropped.
    localparam logic [1:0] SEL_L0      = 2'd0;
    localparam logic [1:0] SEL_L1      = 2'd1;
    localparam logic [1:0] SEL_L2      = 2'd2;
    localparam logic [1:0] SEL_ILLEGAL = 2'd3;

    function automatic logic is_illegal(input logic [1:0] sel);
        return sel == SEL_ILLEGAL;
    endfunction

endpackage

// File: rtl/demux3_stream_if.sv
// Handshake bundle for demux3_stream: one input stream, three output lanes.
// Latency: n/a (wires only).
// Backpressure: in_ready toward the source, out_ready[2:0] from the consumers.
// Ports: in_valid/in_ready/in_data/in_sel (input stream),
//        out_valid/out_ready (per-lane handshake), out_data0..2 (lane words).
interface demux3_stream_if #(
    parameter int WIDTH = demux3_pkg::DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic [2:0]       out_valid;
    logic [2:0]       out_ready;
    logic [WIDTH-1:0] out_data0;
    logic [WIDTH-1:0] out_data1;
    logic [WIDTH-1:0] out_data2;

    // Demultiplexer side.
    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data0, out_data1, out_data2
    );

    // Source + consumers side.
    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data0, out_data1, out_data2
    );
endinterface

// File: rtl/demux_lane_buf.sv
// One-entry output lane buffer (valid + data register).
// Latency: a word loaded at edge N is presented after edge N.
// Backpressure: free = empty or draining this cycle; load overwrites a draining word.
// Ports: clk, rst (sync active-high), load, load_data, out_ready,
//        out_valid, out_data, free.
module demux_lane_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             free
);

    assign free = ~out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            // Covers the fill-while-draining case: the new word replaces
            // the departing one and valid stays high.
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (out_valid && out_ready) begin
            // Data is left untouched so an empty lane keeps its last word.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux3_stream.sv
// 1-to-3 registered demultiplexer: routes each input word to a lane by in_sel, drops sel==3.
// Latency: 1 cycle from input transfer to out_valid on the selected lane.
// Backpressure: in_ready follows the selected lane's free flag; illegal selects are always accepted.
// Ports: clk, rst (sync active-high), bus (demux3_stream_if.slave),
//        err_pulse (one cycle per dropped word), drop_cnt (saturating drop count).
module demux3_stream
    import demux3_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    demux3_stream_if.slave    bus,
    output logic              err_pulse,
    output logic [CNT_W-1:0]  drop_cnt
);

    logic [NUM_LANES-1:0] lane_load;
    logic [NUM_LANES-1:0] lane_free;
    logic [NUM_LANES-1:0] lane_valid;
    logic [WIDTH-1:0]     lane_data [NUM_LANES];
    logic                 sel_ready;
    logic                 drop;

    // Ready is combinational from the select and the addressed lane's state.
    always_comb begin
        sel_ready = 1'b0;
        case (bus.in_sel)
            SEL_L0:  sel_ready = lane_free[0];
            SEL_L1:  sel_ready = lane_free[1];
            SEL_L2:  sel_ready = lane_free[2];
            default: sel_ready = 1'b1;
        endcase
    end

    assign bus.in_ready = sel_ready;

    always_comb begin
        lane_load = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_load[i] = bus.in_valid && sel_ready && (bus.in_sel == 2'(i));
        end
    end

    assign drop = bus.in_valid && is_illegal(bus.in_sel);

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        demux_lane_buf #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .load      (lane_load[g]),
            .load_data (bus.in_data),
            .out_ready (bus.out_ready[g]),
            .out_valid (lane_valid[g]),
            .out_data  (lane_data[g]),
            .free      (lane_free[g])
        );
    end

    assign bus.out_valid = lane_valid;
    assign bus.out_data0 = lane_data[0];
    assign bus.out_data1 = lane_data[1];
    assign bus.out_data2 = lane_data[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            err_pulse <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            err_pulse <= drop;
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/demux3_stream.md
Name: demux3_stream

Overview:
- 1-to-3 registered demultiplexer with valid/ready handshakes. It is the distribution-side counterpart of the team's 3-input selector: it takes one input stream and routes each word to one of three output lanes by a 2-bit select.
- Each lane holds one word in its own buffer, so a stalled lane never corrupts traffic to the other lanes.
- Illegal selects are dropped and counted.

Parameters:
- WIDTH, 8, data width of the input word and of each output lane.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block accepts the input word this cycle.
- in_data  input  WIDTH  input word.
- in_sel  input  2  destination: 0→lane0, 1→lane1, 2→lane2, 3→illegal.
- out_valid  output  3  per-lane valid; bit i belongs to lane i.
- out_ready  input  3  per-lane ready from the consumer.
- out_data0  output  WIDTH  lane0 word.
- out_data1  output  WIDTH  lane1 word.
- out_data2  output  WIDTH  lane2 word.
- err_pulse  output  1  one-cycle pulse when an illegal-select word is dropped.
- drop_cnt  output  CNT_W  saturating count of dropped words.

Behaviour:
- Reset: synchronous, active-high, single clock.
  - At the rising edge with rst=1: out_valid=3'b000, out_data0/1/2=0, err_pulse=0, drop_cnt=0.
  - Reset mid-operation discards all buffered words; in_ready is ignored while rst=1.
- Transfers:
  - An input transfer occurs on the edge where in_valid & in_ready.
  - An output transfer on lane i occurs on the edge where out_valid[i] & out_ready[i].
- Lane buffer, one entry per lane:
  - "Free" means empty, or full and draining this cycle.
  - in_ready = (in_sel==3) | lane[in_sel] free. This is combinational from in_sel, out_valid and out_ready.
- Latency: a word accepted at edge N appears on out_data[sel] with out_valid[sel]=1 after edge N (1 cycle).
- Fill and drain on the same lane in the same cycle:
  - The new word replaces the old one; out_valid stays 1, giving 1 word/cycle sustained throughput per lane.
- Stall: while out_valid[i]=1 and out_ready[i]=0, out_data_i holds stable.
- Lane independence: non-selected lanes are unaffected; their buffers hold or drain independently.
- Illegal select (in_sel==3 with in_valid=1):
  - Always accepted (in_ready=1) and the word is discarded.
  - err_pulse=1 for exactly the following cycle.
  - drop_cnt increments, saturating at 2^CNT_W-1.
- Back-to-back drops give a continuous err_pulse high, one cycle per dropped word.
- in_valid=0: no state change except lane drains; in_sel and in_data are don't-care.
- Protocol rule (verification checks this): once in_valid=1 and in_ready=0, the source holds in_valid, in_sel and in_data stable until the transfer.
- Empty-lane data: out_data_i keeps its last value when out_valid[i]=0 and must not be interpreted by the consumer.

Decomposition:
- Shared package demux3_pkg:
  - NUM_LANES=3.
  - Select constants SEL_L0=2'd0, SEL_L1=2'd1, SEL_L2=2'd2, SEL_ILLEGAL=2'd3.
  - Default WIDTH and CNT_W.
- Sub-module demux_lane_buf:
  - One-entry valid/data register with load, drain and free signals.
  - Instantiated three times.
- The top level holds select decoding, the in_ready mux, and the drop counter with err_pulse.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1, in_sel=0, in_data=8'hAA → out_valid=000, out_data0/1/2=0, drop_cnt=0 and err_pulse=0 after release.
- Routing, all out_ready=1: send 8'h11/sel0, 8'h22/sel1, 8'h33/sel2 on consecutive cycles → each word appears one cycle later on its lane with only that out_valid bit set.
- Stall and hold:
  - out_ready[1]=0; send 8'h5A/sel1, then 8'h5B/sel1 → second word sees in_ready=0.
  - out_data1 holds 8'h5A.
  - Raise out_ready[1] → 5A drains, 5B loads the same edge, then drains.
- Independence: lane0 stalled holding 8'hC0; send 8'hD1/sel2 → accepted immediately and delivered on lane2, while lane0 still holds C0.
- Illegal select:
  - Send 3 words with sel=3 → in_ready=1 each cycle, err_pulse high for 3 cycles, drop_cnt=3.
  - No out_valid bit rises.
- Saturation and reset mid-operation:
  - Drop 260 words → drop_cnt=255.
  - Assert rst with all lanes full → all cleared on the next edge.
